// File: rtl/usb_rx_pkg.sv
// Shared receive-path types and constants for the USB bit unstuffer.
package usb_rx_pkg;
   typedef enum logic [1:0] {IDLE, RUN, STRIP, ERROR} unstuff_state_t;
   localparam int USB_STUFF_RUN = 6;
endpackage

// File: rtl/bit_unstuffer_if.sv
// Serial bit-stream bundle between the NRZI decoder, the unstuffer and the CRC/packet decoder.
interface bit_unstuffer_if;
   logic in_bit;
   logic nrzi_sending;
   logic out_bit;
   logic out_valid;
   logic unstuff_sending;
   logic packet_done;
   logic stuff_err;

   modport master (output in_bit, nrzi_sending,
                   input  out_bit, out_valid, unstuff_sending, packet_done, stuff_err);
   modport slave  (input  in_bit, nrzi_sending,
                   output out_bit, out_valid, unstuff_sending, packet_done, stuff_err);
endinterface

// File: rtl/unstuffer_fsm.sv
// Stuffing state machine and run-of-ones counter; decides per cycle whether a bit is data.
// The BIT_STUFF_ERR_EN macro compiles in violation detection and the ERROR state.
module unstuffer_fsm
   import usb_rx_pkg::*;
#(
   parameter int MAX_ONES = USB_STUFF_RUN
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           in_bit_i,
   input  logic           sending_i,
   output unstuff_state_t state_o,
   output logic           valid_d_o,
   output logic           err_d_o
);
   localparam int CW = $clog2(MAX_ONES + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_ONES);

   unstuff_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q < MAX_ONES whenever a 1 is counted, so the increment cannot wrap
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      valid_d_o = 1'b0;
      err_d_o   = 1'b0;
      if (!sending_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, RUN: begin
               valid_d_o = 1'b1;
               if (in_bit_i) begin
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == MAX_C) ? STRIP : RUN;
               end else begin
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            STRIP: begin
               if (!in_bit_i) begin
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
`ifdef BIT_STUFF_ERR_EN
                  err_d_o = 1'b1;
                  cnt_d   = '0;
                  state_d = ERROR;
`else
                  // tolerate the violation: keep the 1 as data and start a new run
                  valid_d_o = 1'b1;
                  cnt_d     = CW'(1);
                  state_d   = RUN;
`endif
               end
            end
`ifdef BIT_STUFF_ERR_EN
            ERROR: state_d = ERROR;
`endif
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign state_o = state_q;
endmodule

// File: rtl/bit_unstuffer.sv
// Bit unstuffer top: registers every output one cycle after its input and flags packet end.
// Optional macro BIT_STUFF_ERR_EN enables stuff_err and the ERROR state.
module bit_unstuffer
   import usb_rx_pkg::*;
#(
   parameter int MAX_ONES = USB_STUFF_RUN
) (
   input  logic            clock,
   input  logic            reset_n,
   bit_unstuffer_if.slave  bus
);
   unstuff_state_t state;
   logic           valid_d, err_d;
   logic           out_bit_q, out_valid_q, sending_q, done_q, err_q;

   unstuffer_fsm #(.MAX_ONES(MAX_ONES)) u_fsm (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_bit_i  (bus.in_bit),
      .sending_i (bus.nrzi_sending),
      .state_o   (state),
      .valid_d_o (valid_d),
      .err_d_o   (err_d)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         sending_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_bit_q   <= bus.in_bit & valid_d;
         out_valid_q <= valid_d;
         sending_q   <= bus.nrzi_sending;
         // keyed on state, not on the delayed qualifier, so a reset-aborted packet never reports done
         done_q      <= (state != IDLE) & ~bus.nrzi_sending;
`ifdef BIT_STUFF_ERR_EN
         err_q       <= err_d;
`else
         err_q       <= 1'b0;
`endif
      end
   end

   assign bus.out_bit         = out_bit_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.unstuff_sending = sending_q;
   assign bus.packet_done     = done_q;
   assign bus.stuff_err       = err_q;
endmodule
